// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, returning {remainder, quotient}.
// Holds div_stall_request until the result is ready in the END state.
module seq_divider #(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     FUNCT_WIDTH = 6,
    parameter logic [FUNCT_WIDTH-1:0] FUNCT_DIV   = 6'b011010,
    parameter logic [FUNCT_WIDTH-1:0] FUNCT_DIVU  = 6'b011011
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FUNCT_WIDTH-1:0]    funct,
    input  logic [DATA_WIDTH-1:0]     operand_1,
    input  logic [DATA_WIDTH-1:0]     operand_2,
    input  logic                      cancel_div,
    output logic                      div_stall_request,
    output logic [2*DATA_WIDTH-1:0]   result_div
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   divisor;
    logic [DATA_WIDTH-1:0]   partial_rem;
    logic [DATA_WIDTH-1:0]   dq;          // dividend bits shift out the top, quotient bits shift in the bottom
    logic                    sign_q, sign_r;

    logic                    is_div, op_signed;
    logic [DATA_WIDTH:0]     rem_s;
    logic [DATA_WIDTH-1:0]   trial;
    logic                    borrow;
    logic [DATA_WIDTH-1:0]   rem_nx, quo_nx;

    function automatic logic [DATA_WIDTH-1:0] neg_if(input logic neg, input logic [DATA_WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic is_signed, input logic [DATA_WIDTH-1:0] v);
        return neg_if(is_signed & v[DATA_WIDTH-1], v);
    endfunction

    always_comb begin
        is_div     = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
        op_signed  = (funct == FUNCT_DIV);
        state_next = state;
        div_stall_request = 1'b0;

        // One restoring step: the shifted partial remainder needs DATA_WIDTH+1 bits.
        rem_s  = {partial_rem, dq[DATA_WIDTH-1]};
        borrow = (rem_s < {1'b0, divisor});
        trial  = rem_s[DATA_WIDTH-1:0] - divisor;
        rem_nx = borrow ? rem_s[DATA_WIDTH-1:0] : trial;
        quo_nx = {dq[DATA_WIDTH-2:0], ~borrow};

        case (state)
            S_IDLE: begin
                div_stall_request = is_div && !cancel_div;
                if (is_div && !cancel_div)
                    state_next = (operand_2 == '0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: begin
                div_stall_request = !cancel_div;
                state_next = cancel_div ? S_IDLE : S_END;
            end
            S_ON: begin
                div_stall_request = !cancel_div;
                if (cancel_div)
                    state_next = S_IDLE;
                else if (cnt == LAST_ITER)
                    state_next = S_END;
            end
            S_END: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            divisor     <= '0;
            partial_rem <= '0;
            dq          <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            result_div  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (is_div && !cancel_div) begin
                        divisor     <= magnitude(op_signed, operand_2);
                        dq          <= magnitude(op_signed, operand_1);
                        partial_rem <= '0;
                        cnt         <= '0;
                        sign_q      <= op_signed & (operand_1[DATA_WIDTH-1] ^ operand_2[DATA_WIDTH-1]);
                        sign_r      <= op_signed & operand_1[DATA_WIDTH-1];
                    end
                end
                S_ON: begin
                    if (!cancel_div) begin
                        partial_rem <= rem_nx;
                        dq          <= quo_nx;
                        cnt         <= cnt + 1'b1;
                        if (cnt == LAST_ITER)
                            result_div <= {neg_if(sign_r, rem_nx), neg_if(sign_q, quo_nx)};
                    end
                end
                S_BYZERO: begin
                    if (!cancel_div)
                        result_div <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
